// File: rtl/engine_read_write_request_issuer.sv
// rtl/engine_read_write_request_issuer.sv - buffers kernel entries and issues single-beat memory requests
// Read credit limits in-flight reads; done once the last entry issues and all read responses return.
module engine_read_write_request_issuer #(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 32,
   parameter int ID_W            = 4,
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                               ap_clk,
   input  logic                               areset,
   input  logic                               start_in,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_last,
   input  logic                               in_write,
   input  logic [ADDR_W-1:0]                  in_offset,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic [ID_W-1:0]                    in_id_buffer,
   output logic                               req_valid,
   input  logic                               req_ready,
   output logic                               req_write,
   output logic [ADDR_W-1:0]                  req_offset,
   output logic [DATA_W-1:0]                  req_data,
   output logic [ID_W-1:0]                    req_id_buffer,
   input  logic                               resp_valid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out,
   output logic                               done_out,
   output logic                               error_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int EW = 1 + ADDR_W + DATA_W + ID_W;
   localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [OW-1:0]   os_q, os_d;
   logic            error_q, error_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];

   logic [EW-1:0]   head;
   logic            head_write, full, empty, push, pop, rd_xfer, start_go;

   assign head       = mem_q[rd_ptr_q];
   assign head_write = head[EW-1];
   assign full       = (count_q == DEPTH);
   assign empty      = (count_q == '0);
   assign push       = in_valid && in_ready;
   assign pop        = req_valid && req_ready;
   assign rd_xfer    = pop && !head_write;
   assign start_go   = start_in && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_in) state_d = RUN;
         RUN:     if (push && in_last) state_d = DRAIN;
         DRAIN:   if (empty && (os_q == '0) && !pop) state_d = DONE;
         DONE:    if (start_in) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == RUN) && !full;
      req_valid = !empty && ((state_q == RUN) || (state_q == DRAIN)) &&
                  (head_write || (os_q < MAX_OS));
      done_out  = (state_q == DONE);
   end

   // Fields are gated by valid so reset shows zeros without resetting the storage array.
   assign {req_write, req_offset, req_data, req_id_buffer} = req_valid ? head : '0;
   assign outstanding_out = os_q;
   assign error_out       = error_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_comb begin
      os_d    = os_q;
      error_d = error_q;
      if (rd_xfer && !resp_valid) begin
         os_d = os_q + OW'(1);
      end else if (!rd_xfer && resp_valid) begin
         if (os_q == '0) error_d = 1'b1;
         else            os_d    = os_q - OW'(1);
      end
      if (start_go) error_d = 1'b0;
   end

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         os_q     <= '0;
         error_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         os_q    <= os_d;
         error_q <= error_d;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_write, in_offset, in_data, in_id_buffer};
   end

endmodule

// File: tb/tb_engine_read_write_request_issuer.sv
// tb/tb_engine_read_write_request_issuer.sv - randomized bench with queue-based reference model
// The model keeps issued-order entries in a queue and applies the run/drain/credit rules directly.
module tb_engine_read_write_request_issuer;

   localparam int DEPTH = 16;
   localparam int MAXOS = 2;
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   typedef struct packed {
      logic        w;
      logic [63:0] off;
      logic [31:0] data;
      logic [3:0]  id;
   } ent_t;

   logic        ap_clk = 1'b0;
   logic        areset = 1'b1;
   logic        start_in = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_write = 1'b0;
   logic [63:0] in_offset = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_id_buffer = '0;
   logic        req_ready = 1'b0, resp_valid = 1'b0;
   logic        in_ready, req_valid, req_write, done_out, error_out;
   logic [63:0] req_offset;
   logic [31:0] req_data;
   logic [3:0]  req_id_buffer;
   logic [1:0]  outstanding_out;

   engine_read_write_request_issuer #(
      .ADDR_W(64), .DATA_W(32), .ID_W(4), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOS)
   ) dut (
      .ap_clk(ap_clk), .areset(areset), .start_in(start_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_write(in_write),
      .in_offset(in_offset), .in_data(in_data), .in_id_buffer(in_id_buffer),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_offset(req_offset), .req_data(req_data), .req_id_buffer(req_id_buffer),
      .resp_valid(resp_valid), .outstanding_out(outstanding_out),
      .done_out(done_out), .error_out(error_out)
   );

   initial forever #5 ap_clk = ~ap_clk;

   int   n_tests = 0, n_fail = 0;
   ent_t m_q[$];
   ent_t dir_q[$];
   int   m_phase = P_IDLE, m_os = 0;
   bit   m_err = 0, m_ir = 0, m_rv = 0, m_pushed = 0;
   bit   prev_hold = 0;
   logic [63:0] prev_off = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_phase = P_IDLE; m_os = 0; m_err = 0; prev_hold = 0;
   endtask

   task automatic check_outputs();
      m_ir = (m_phase == P_RUN) && (m_q.size() < DEPTH);
      m_rv = (m_q.size() > 0) && ((m_phase == P_RUN) || (m_phase == P_DRAIN)) &&
             (m_q[0].w || (m_os < MAXOS));
      check("in_ready", 64'(in_ready), 64'(m_ir));
      check("req_valid", 64'(req_valid), 64'(m_rv));
      check("outstanding", 64'(outstanding_out), 64'(m_os));
      check("done_out", 64'(done_out), 64'(m_phase == P_DONE));
      check("error_out", 64'(error_out), 64'(m_err));
      if (m_rv) begin
         check("req_write", 64'(req_write), 64'(m_q[0].w));
         check("req_offset", req_offset, m_q[0].off);
         check("req_data", 64'(req_data), 64'(m_q[0].data));
         check("req_id", 64'(req_id_buffer), 64'(m_q[0].id));
      end
      if (prev_hold) check("req_hold", req_offset, prev_off);
   endtask

   task automatic step(input bit st, input bit iv, input ent_t e, input bit il,
                       input bit rr, input bit rv);
      bit push, pop, rd;
      int nxt;
      @(negedge ap_clk);
      check_outputs();
      start_in = st; in_valid = iv; in_last = il; in_write = e.w;
      in_offset = e.off; in_data = e.data; in_id_buffer = e.id;
      req_ready = rr; resp_valid = rv;
      push = iv && m_ir;
      pop  = m_rv && rr;
      rd   = pop && !m_q[0].w;
      prev_hold = m_rv && !rr;
      prev_off  = req_offset;
      nxt = m_phase;
      case (m_phase)
         P_IDLE:  if (st) nxt = P_RUN;
         P_RUN:   if (push && il) nxt = P_DRAIN;
         P_DRAIN: if (m_q.size() == 0 && m_os == 0 && !pop) nxt = P_DONE;
         default: if (st) nxt = P_RUN;
      endcase
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      if (rd && !rv) m_os++;
      else if (!rd && rv) begin
         if (m_os == 0) m_err = 1;
         else m_os--;
      end
      if (st && (m_phase == P_IDLE || m_phase == P_DONE)) m_err = 0;
      m_phase  = nxt;
      m_pushed = push;
   endtask

   function automatic ent_t rand_ent(input int wr_pct);
      ent_t e;
      e.w    = ($urandom_range(99) < wr_pct);
      e.off  = {$urandom, $urandom};
      e.data = $urandom;
      e.id   = 4'($urandom_range(15));
      return e;
   endfunction

   task automatic run(input int n, input int iv_pct, input int wr_pct, input int rdy_pct,
                      input int resp_pct, input int rdy_hold, input int resp_hold,
                      input int budget);
      bit   pend = 0, done_seen = 0, iv, rr, rv;
      ent_t e = '0;
      int   left = n;
      step(1, 0, '0, 0, 0, 0);
      for (int c = 0; c < budget && !done_seen; c++) begin
         if (!pend && left > 0) begin
            if (dir_q.size() > 0) e = dir_q.pop_front();
            else e = rand_ent(wr_pct);
            pend = 1;
         end
         iv = pend && ($urandom_range(99) < iv_pct);
         rr = (c >= rdy_hold) && ($urandom_range(99) < rdy_pct);
         rv = (m_os > 0) && (c >= resp_hold) && ($urandom_range(99) < resp_pct);
         step(0, iv, e, left == 1, rr, rv);
         if (m_pushed) begin pend = 0; left--; end
         if (m_phase == P_DONE) done_seen = 1;
      end
      step(0, 0, '0, 0, 0, 0);
      check("run_completes", 64'(done_out), 64'd1);
   endtask

   initial begin
      ent_t e;
      bit   rr;
      int   nrd;
      model_reset();
      #12;
      check_outputs();
      check("rst_req_offset", req_offset, 64'd0);
      @(negedge ap_clk);
      areset = 1'b0;

      // three directed writes, always ready
      for (int i = 0; i < 3; i++) begin
         e.w = 1; e.off = 64'h10 + 64'(4 * i); e.data = 32'hA0 + 32'(i); e.id = 4'(i + 1);
         dir_q.push_back(e);
      end
      run(3, 100, 100, 100, 0, 0, 0, 100);

      // four reads against two credits; responses held back for a while
      run(4, 100, 0, 100, 40, 0, 20, 300);

      // stall the memory side until the FIFO fills, then drain
      run(20, 100, 100, 100, 0, 40, 0, 300);

      // mixed random runs
      for (int r = 0; r < 6; r++)
         run($urandom_range(30, 1), 75, 50, 60, 45, 0, 0, 1000);

      // spurious response while idle in DONE, then cleared by start
      step(0, 0, '0, 0, 0, 1);
      step(0, 0, '0, 0, 0, 0);
      check("error_sticky", 64'(error_out), 64'd1);
      run(5, 75, 50, 80, 50, 0, 0, 500);

      // build 5 buffered entries with 2 reads in flight, then reset mid-run
      step(1, 0, '0, 0, 0, 0);
      nrd = 0;
      for (int c = 0; c < 60 && !(m_q.size() == 5 && m_os == 2); c++) begin
         e = rand_ent(100);
         e.w = (nrd >= 2);
         rr = (m_q.size() > 0) && !m_q[0].w;
         step(0, (m_q.size() + nrd < 7) || (nrd < 2 && m_q.size() < 5), e, 0, rr, 0);
         if (m_pushed && !e.w) nrd++;
      end
      step(0, 0, '0, 0, 0, 0);
      check("pre_rst_outstanding", 64'(outstanding_out), 64'd2);
      #2 areset = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_outstanding", 64'(outstanding_out), 64'd0);
      check("rst_done", 64'(done_out), 64'd0);
      check("rst_error", 64'(error_out), 64'd0);
      check("rst_req_off", req_offset, 64'd0);
      model_reset();
      @(negedge ap_clk);
      @(negedge ap_clk);
      areset = 1'b0;
      start_in = 0; in_valid = 0; req_ready = 0; resp_valid = 0;
      e.w = 1; e.off = 64'h40; e.data = 32'h55; e.id = 4'h7;
      dir_q.push_back(e);
      run(1, 100, 100, 100, 0, 0, 0, 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/engine_read_write_request_issuer.md
Name: engine_read_write_request_issuer

Overview:
- Downstream neighbour of the read/write engine kernel.
- Accepts the kernel's per-packet address and data stream: offset, buffer id, read/write mode and write data.
- Buffers entries in a small FIFO and issues them as single-beat memory requests over a valid/ready handshake.
- Bounds in-flight reads with a credit counter, and signals completion once the last entry is issued and all read responses have returned.

Parameters:
- ADDR_W, 64, request offset width
- DATA_W, 32, write data width
- ID_W, 4, buffer id width
- FIFO_DEPTH, 16, request FIFO entries; must be a power of 2, minimum 2
- MAX_OUTSTANDING, 8, maximum in-flight reads; minimum 1

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- areset  in  1  asynchronous active-high reset
- start_in  in  1  single-cycle pulse; begins a run
- in_valid  in  1  kernel entry valid
- in_ready  out  1  block can accept an entry
- in_last  in  1  entry is the final one of the run
- in_write  in  1  1 = write request, 0 = read request
- in_offset  in  ADDR_W  request offset, already shifted by the kernel
- in_data  in  DATA_W  write data; don't-care for reads
- in_id_buffer  in  ID_W  target buffer id
- req_valid  out  1  memory request valid
- req_ready  in  1  memory side accepts the request
- req_write  out  1  request type
- req_offset  out  ADDR_W  request offset
- req_data  out  DATA_W  request write data
- req_id_buffer  out  ID_W  request buffer id
- resp_valid  in  1  one read response retired this cycle
- outstanding_out  out  $clog2(MAX_OUTSTANDING+1)  current in-flight read count
- done_out  out  1  run complete
- error_out  out  1  sticky: response received with zero reads outstanding

Behaviour:
- Reset (async assert, synchronous-release use):
  - state = IDLE; FIFO empty; outstanding = 0.
  - All outputs 0, including req_valid, in_ready, done_out and error_out.
  - Reset mid-run discards all FIFO contents and in-flight accounting.
- State machine, states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start_in.
  - RUN -> DRAIN on the cycle an entry with in_last=1 is pushed.
  - DRAIN -> DONE when FIFO is empty, outstanding == 0, and no request is transferring this cycle.
  - DONE -> RUN on start_in; this also clears error_out and done_out.
  - start_in is ignored in RUN and DRAIN.
- Accept side:
  - in_ready = (state == RUN) && !full. It is 0 in IDLE, DRAIN and DONE.
  - Push on in_valid && in_ready.
  - Each FIFO entry stores {write, offset, data, id_buffer}.
- Issue side:
  - FIFO read data is registered, so the head is visible on req_* no earlier than the cycle after its push (minimum 1-cycle latency).
  - req_valid = !empty && (state ∈ {RUN, DRAIN}) && (head.write || outstanding < MAX_OUTSTANDING).
  - Pop on req_valid && req_ready.
  - While req_valid && !req_ready, req_valid and all req_* fields hold stable.
  - A read at the head blocked by credit also blocks the writes behind it; order is strictly FIFO.
- Outstanding counter:
  - +1 on a read transfer; -1 on resp_valid; unchanged when both happen in the same cycle.
  - resp_valid with outstanding == 0 and no read transfer that cycle: counter stays 0 and error_out is set.
  - Writes never count.
- Occupancy:
  - Push and pop may occur in the same cycle at any non-full occupancy; count is unchanged.
  - Full means count == FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- done_out is 1 only in DONE.

Test Plan:
- Reset, start_in, then 3 writes (offsets 0x10, 0x14, 0x18; last on the third) with req_ready=1 -> req_* show all three in order, each one cycle after its push; outstanding_out stays 0; done_out=1 two cycles after the final transfer.
- MAX_OUTSTANDING=2, 4 reads pushed, no resp_valid -> exactly 2 transfer and req_valid drops; each resp_valid pulse releases exactly one more read; done_out rises after the 4th response.
- Hold req_ready=0 and push 16 entries -> in_ready=0 once count reaches 16 and the 17th in_valid is not accepted; req_offset holds stable; after release all 16 issue in order.
- Read transfer coincident with resp_valid at outstanding=1 -> outstanding_out stays 1; a resp_valid at outstanding=0 -> error_out=1, cleared by the next start_in from DONE.
- Assert areset mid-run with 5 entries buffered and 2 reads outstanding -> all outputs 0 immediately, FIFO empty, state IDLE; a subsequent start_in and a single last write completes normally.
